// File: rtl/lcd_pkg.sv
// Shared constants and types for the SPI LCD controller responder.
// Holds panel geometry, instruction opcode masks/values, the decode FSM
// state type and the configuration register bundle with its reset value.
package lcd_pkg;

  localparam int unsigned LCD_COLS = 84;
  localparam int unsigned LCD_ROWS = 6;

  // Opcode mask/value pairs: a byte b matches when (b & MASK) == VAL.
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] FSET_MASK = 8'hE0;
  localparam logic [7:0] FSET_VAL  = 8'h20;
  localparam logic [7:0] DISP_MASK = 8'hFA;
  localparam logic [7:0] DISP_VAL  = 8'h08;
  localparam logic [7:0] SETY_MASK = 8'hF8;
  localparam logic [7:0] SETY_VAL  = 8'h40;
  localparam logic [7:0] SETX_MASK = 8'h80;
  localparam logic [7:0] SETX_VAL  = 8'h80;
  localparam logic [7:0] TC_MASK   = 8'hFC;
  localparam logic [7:0] TC_VAL    = 8'h04;
  localparam logic [7:0] BIAS_MASK = 8'hF8;
  localparam logic [7:0] BIAS_VAL  = 8'h10;
  localparam logic [7:0] VOP_MASK  = 8'h80;
  localparam logic [7:0] VOP_VAL   = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic       pd;
    logic       v_mode;
    logic       h;
    logic [1:0] disp_de;
    logic [6:0] vop;
    logic [2:0] bias;
    logic [1:0] tc;
  } cfg_t;

  // Panel powers up in power-down with everything else cleared.
  localparam cfg_t CFG_RST = '{pd: 1'b1, v_mode: 1'b0, h: 1'b0, disp_de: 2'b00,
                               vop: 7'h00, bias: 3'b000, tc: 2'b00};

  function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                    input logic [7:0] val);
    return (b & mask) == val;
  endfunction

endpackage

// File: rtl/lcd_spi_sync.sv
// Input synchronizer and SPI clock rising-edge detector.
// Ports: clk/rst_n system clock and async active-low reset;
//   sclk_i/sce_i/mosi_i/dc_i/lcd_rst_i raw pins from the SPI master;
//   sce_s_o/mosi_s_o/dc_s_o/lcd_rst_s_o synchronized levels;
//   sclk_rise_c_o combinational one-cycle pulse on a synchronized sclk 0->1.
module lcd_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic sce_i,
  input  logic mosi_i,
  input  logic dc_i,
  input  logic lcd_rst_i,
  output logic sce_s_o,
  output logic mosi_s_o,
  output logic dc_s_o,
  output logic lcd_rst_s_o,
  output logic sclk_rise_c_o
);

  localparam int unsigned NSIG = 5;
  // Bit order {lcd_rst, dc, mosi, sce, sclk}. sclk resets high so a pin that
  // is already high when reset releases is not mistaken for a rising edge.
  localparam logic [NSIG-1:0] RST_VAL = 5'b10011;

  logic [NSIG-1:0] stage_q [SYNC_STAGES];
  logic            sclk_prev_q;

  // Synchronizer chains plus the delayed sclk used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= RST_VAL;
      sclk_prev_q <= 1'b1;
    end else begin
      stage_q[0] <= {lcd_rst_i, dc_i, mosi_i, sce_i, sclk_i};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      sclk_prev_q <= stage_q[SYNC_STAGES-1][0];
    end
  end

  assign lcd_rst_s_o   = stage_q[SYNC_STAGES-1][4];
  assign dc_s_o        = stage_q[SYNC_STAGES-1][3];
  assign mosi_s_o      = stage_q[SYNC_STAGES-1][2];
  assign sce_s_o       = stage_q[SYNC_STAGES-1][1];
  assign sclk_rise_c_o = stage_q[SYNC_STAGES-1][0] & ~sclk_prev_q;

endmodule

// File: rtl/lcd_spi_responder.sv
// SPI LCD controller responder: receives bytes, decodes commands into
// configuration registers and turns data bytes into frame-buffer writes.
// Ports: clk/rst_n; SPI pins sclk_i, sce_i, mosi_i, dc_i, lcd_rst_i;
//   byte_valid_o/byte_out_o/byte_dc_o received-byte report;
//   wr_en_o/wr_addr_o/wr_data_o frame-buffer write port;
//   x_addr_o/y_addr_o address pointers; pd_o/v_mode_o/h_o/disp_de_o and
//   vop_o/bias_o/tc_o configuration; cmd_err_o sticky range error.
module lcd_spi_responder
  import lcd_pkg::*;
#(
  parameter int unsigned COLS        = LCD_COLS,
  parameter int unsigned ROWS        = LCD_ROWS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       sce_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  input  logic       lcd_rst_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_out_o,
  output logic       byte_dc_o,
  output logic       wr_en_o,
  output logic [8:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [6:0] x_addr_o,
  output logic [2:0] y_addr_o,
  output logic       pd_o,
  output logic       v_mode_o,
  output logic       h_o,
  output logic [1:0] disp_de_o,
  output logic [6:0] vop_o,
  output logic [2:0] bias_o,
  output logic [1:0] tc_o,
  output logic       cmd_err_o
);

  logic sce_s, mosi_s, dc_s, lcd_rst_s, sclk_rise;

  lcd_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_i       (sclk_i),
    .sce_i        (sce_i),
    .mosi_i       (mosi_i),
    .dc_i         (dc_i),
    .lcd_rst_i    (lcd_rst_i),
    .sce_s_o      (sce_s),
    .mosi_s_o     (mosi_s),
    .dc_s_o       (dc_s),
    .lcd_rst_s_o  (lcd_rst_s),
    .sclk_rise_c_o(sclk_rise)
  );

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_dc_q, byte_dc_d;
  logic       wr_en_q, wr_en_d;
  logic [8:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [6:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  cfg_t       cfg_q, cfg_d;
  logic       cmd_err_q, cmd_err_d;

  logic [7:0] rx_byte;
  logic [8:0] lin_addr;
  logic       x_last, y_last;

  assign rx_byte  = {shift_q[6:0], mosi_s};
  assign lin_addr = 9'((32'(y_q) * COLS) + 32'(x_q));
  assign x_last   = (32'(x_q) == COLS - 1);
  assign y_last   = (32'(y_q) == ROWS - 1);

  // Next-state: FSM, shifter, command decode and address pointer update.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    x_d          = x_q;
    y_d          = y_q;
    cfg_d        = cfg_q;
    cmd_err_d    = cmd_err_q;

    case (state_q)
      ST_IDLE:            if (!sce_s) state_d = ST_SHIFT;
      ST_SHIFT, ST_DONE:  state_d = sce_s ? ST_IDLE : ST_SHIFT;
      default:            state_d = ST_IDLE;
    endcase

    if (sce_s) begin
      cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d = rx_byte;
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d      = ST_DONE;
        byte_valid_d = 1'b1;
        byte_d       = rx_byte;
        byte_dc_d    = dc_s;
        if (dc_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = lin_addr;
          wr_data_d = rx_byte;
          // Horizontal mode walks columns first, vertical walks banks first.
          if (!cfg_q.v_mode) begin
            x_d = x_last ? 7'd0 : x_q + 7'd1;
            if (x_last) y_d = y_last ? 3'd0 : y_q + 3'd1;
          end else begin
            y_d = y_last ? 3'd0 : y_q + 3'd1;
            if (y_last) x_d = x_last ? 7'd0 : x_q + 7'd1;
          end
        end else if (rx_byte != OP_NOP) begin
          if (op_match(rx_byte, FSET_MASK, FSET_VAL)) begin
            cfg_d.pd     = rx_byte[2];
            cfg_d.v_mode = rx_byte[1];
            cfg_d.h      = rx_byte[0];
          end else if (!cfg_q.h) begin
            if (op_match(rx_byte, SETX_MASK, SETX_VAL)) begin
              if (32'(rx_byte[6:0]) < COLS) x_d = rx_byte[6:0];
              else                          cmd_err_d = 1'b1;
            end else if (op_match(rx_byte, SETY_MASK, SETY_VAL)) begin
              if (32'(rx_byte[2:0]) < ROWS) y_d = rx_byte[2:0];
              else                          cmd_err_d = 1'b1;
            end else if (op_match(rx_byte, DISP_MASK, DISP_VAL)) begin
              cfg_d.disp_de = {rx_byte[2], rx_byte[0]};
            end
          end else begin
            if (op_match(rx_byte, VOP_MASK, VOP_VAL))        cfg_d.vop  = rx_byte[6:0];
            else if (op_match(rx_byte, BIAS_MASK, BIAS_VAL)) cfg_d.bias = rx_byte[2:0];
            else if (op_match(rx_byte, TC_MASK, TC_VAL))     cfg_d.tc   = rx_byte[1:0];
          end
        end
      end
    end

    // Panel reset from the master wins over everything, aborting any byte.
    if (!lcd_rst_s) begin
      state_d      = ST_IDLE;
      shift_d      = 8'h00;
      cnt_d        = 3'd0;
      byte_valid_d = 1'b0;
      byte_d       = 8'h00;
      byte_dc_d    = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = 9'd0;
      wr_data_d    = 8'h00;
      x_d          = 7'd0;
      y_d          = 3'd0;
      cfg_d        = CFG_RST;
      cmd_err_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      cnt_q        <= 3'd0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      byte_dc_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 9'd0;
      wr_data_q    <= 8'h00;
      x_q          <= 7'd0;
      y_q          <= 3'd0;
      cfg_q        <= CFG_RST;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cfg_q        <= cfg_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_out_o   = byte_q;
  assign byte_dc_o    = byte_dc_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign x_addr_o     = x_q;
  assign y_addr_o     = y_q;
  assign pd_o         = cfg_q.pd;
  assign v_mode_o     = cfg_q.v_mode;
  assign h_o          = cfg_q.h;
  assign disp_de_o    = cfg_q.disp_de;
  assign vop_o        = cfg_q.vop;
  assign bias_o       = cfg_q.bias;
  assign tc_o         = cfg_q.tc;
  assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_lcd_spi_responder.sv
// Self-checking bench for lcd_spi_responder: directed sequences plus random
// bytes, checked against a geometry-level model of the controller.
module tb_lcd_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n, sclk, sce, mosi, dc, lcd_rst;
  logic       byte_valid, byte_dc, wr_en, pd, v_mode, h, cmd_err;
  logic [7:0] byte_out, wr_data;
  logic [8:0] wr_addr;
  logic [6:0] x_addr, vop;
  logic [2:0] y_addr, bias;
  logic [1:0] disp_de, tc;

  lcd_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .sce_i(sce), .mosi_i(mosi),
    .dc_i(dc), .lcd_rst_i(lcd_rst), .byte_valid_o(byte_valid),
    .byte_out_o(byte_out), .byte_dc_o(byte_dc), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .x_addr_o(x_addr),
    .y_addr_o(y_addr), .pd_o(pd), .v_mode_o(v_mode), .h_o(h),
    .disp_de_o(disp_de), .vop_o(vop), .bias_o(bias), .tc_o(tc),
    .cmd_err_o(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: counts strobes and captures what was reported with them.
  int         nvalid = 0, nwr = 0;
  logic [7:0] cap_byte = 8'h00, cap_data = 8'h00;
  logic       cap_dc = 1'b0;
  logic [8:0] cap_addr = 9'd0;
  always @(negedge clk) begin
    if (byte_valid) begin
      nvalid   <= nvalid + 1;
      cap_byte <= byte_out;
      cap_dc   <= byte_dc;
    end
    if (wr_en) begin
      nwr      <= nwr + 1;
      cap_addr <= wr_addr;
      cap_data <= wr_data;
    end
  end

  // Reference model state.
  int         m_x, m_y;
  logic       m_pd, m_v, m_h, m_err;
  logic [1:0] m_de, m_tc;
  logic [6:0] m_vop;
  logic [2:0] m_bias;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_pd = 1'b1; m_v = 1'b0; m_h = 1'b0; m_err = 1'b0;
    m_de = 2'b00; m_tc = 2'b00; m_vop = 7'h00; m_bias = 3'b000;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic d);
    int lin;
    if (d) begin
      if (!m_v) begin
        lin = (m_y * 84 + m_x + 1) % 504;
        m_x = lin % 84; m_y = lin / 84;
      end else begin
        lin = (m_x * 6 + m_y + 1) % 504;
        m_x = lin / 6; m_y = lin % 6;
      end
    end else if (b == 8'h00) begin
      m_x = m_x;
    end else if (b[7:5] == 3'b001) begin
      m_pd = b[2]; m_v = b[1]; m_h = b[0];
    end else if (!m_h) begin
      if (b[7]) begin
        if (int'(b[6:0]) < 84) m_x = int'(b[6:0]); else m_err = 1'b1;
      end else if (b[7:3] == 5'b01000) begin
        if (int'(b[2:0]) < 6) m_y = int'(b[2:0]); else m_err = 1'b1;
      end else if (b[7:3] == 5'b00001 && b[1] == 1'b0) begin
        m_de = {b[2], b[0]};
      end
    end else begin
      if (b[7]) m_vop = b[6:0];
      else if (b[7:3] == 5'b00010) m_bias = b[2:0];
      else if (b[7:2] == 6'b000001) m_tc = b[1:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".x"},     32'(x_addr),  32'(m_x));
    chk({tag, ".y"},     32'(y_addr),  32'(m_y));
    chk({tag, ".pd"},    32'(pd),      32'(m_pd));
    chk({tag, ".v"},     32'(v_mode),  32'(m_v));
    chk({tag, ".h"},     32'(h),       32'(m_h));
    chk({tag, ".de"},    32'(disp_de), 32'(m_de));
    chk({tag, ".vop"},   32'(vop),     32'(m_vop));
    chk({tag, ".bias"},  32'(bias),    32'(m_bias));
    chk({tag, ".tc"},    32'(tc),      32'(m_tc));
    chk({tag, ".err"},   32'(cmd_err), 32'(m_err));
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk); sclk = 1'b0; mosi = v;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    int         nv0, nw0;
    logic [8:0] ea;
    nv0 = nvalid; nw0 = nwr;
    ea  = 9'(m_y * 84 + m_x);
    sce = 1'b0; dc = d;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    repeat (6) @(negedge clk);
    chk("valid_count", 32'(nvalid), 32'(nv0 + 1));
    chk("byte_out",    32'(cap_byte), 32'(b));
    chk("byte_dc",     32'(cap_dc),   32'(d));
    chk("wr_count",    32'(nwr),      32'(nw0 + (d ? 1 : 0)));
    if (d) begin
      chk("wr_addr", 32'(cap_addr), 32'(ea));
      chk("wr_data", 32'(cap_data), 32'(b));
    end
    model_byte(b, d);
    check_regs("regs");
  endtask

  task automatic end_frame();
    @(negedge clk); sce = 1'b1; sclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int nv0, nw0;
    logic [7:0] rb;
    logic       rd;
    rst_n = 1'b0; sclk = 1'b0; sce = 1'b1; mosi = 1'b0; dc = 1'b0; lcd_rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_regs("reset");
    chk("reset.valid", 32'(byte_valid), 32'd0);
    chk("reset.wr_en", 32'(wr_en),      32'd0);

    // Init sequence.
    send_byte(8'h21, 1'b0); chk("init.h1",  32'(h),       32'd1);
    send_byte(8'h90, 1'b0); chk("init.vop", 32'(vop),     32'h10);
    send_byte(8'h20, 1'b0); chk("init.h0",  32'(h),       32'd0);
    send_byte(8'h0C, 1'b0); chk("init.de",  32'(disp_de), 32'd2);
    chk("init.no_wr", 32'(nwr), 32'd0);

    // Explicit addressing then one data byte.
    send_byte(8'h8A, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'hAA, 1'b1);
    chk("setxy.addr", 32'(cap_addr), 32'd178);
    chk("setxy.x",    32'(x_addr),   32'd11);
    chk("setxy.y",    32'(y_addr),   32'd2);

    // Full frame in horizontal mode wraps back to the origin.
    send_byte(8'h80, 1'b0);
    send_byte(8'h40, 1'b0);
    for (int i = 0; i < 504; i++) send_byte(8'h00, 1'b1);
    chk("frame.last_addr", 32'(cap_addr), 32'd503);
    chk("frame.x", 32'(x_addr), 32'd0);
    chk("frame.y", 32'(y_addr), 32'd0);

    // Vertical mode walks banks first.
    send_byte(8'h22, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'(i + 1), 1'b1);
    chk("vmode.last_addr", 32'(cap_addr), 32'd1);
    send_byte(8'h20, 1'b0);

    // Out-of-range pointers raise the sticky error.
    send_byte(8'h47, 1'b0);
    send_byte(8'hD4, 1'b0);
    chk("range.err", 32'(cmd_err), 32'd1);
    end_frame();

    // Partial byte is dropped when sce rises.
    sce = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    nv0 = nvalid;
    end_frame();
    chk("partial.no_valid", 32'(nvalid), 32'(nv0));
    send_byte(8'h3C, 1'b0);
    end_frame();

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      rb = 8'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      send_byte(rb, rd);
    end
    end_frame();

    // Panel reset mid-byte aborts it and restores defaults.
    send_byte(8'h21, 1'b0);
    send_byte(8'hC5, 1'b0);
    nv0 = nvalid; nw0 = nwr;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk); lcd_rst = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rst = 1'b1;
    repeat (6) @(negedge clk);
    model_reset();
    chk("lcdrst.no_valid", 32'(nvalid), 32'(nv0));
    chk("lcdrst.no_wr",    32'(nwr),    32'(nw0));
    check_regs("lcdrst");
    end_frame();

    // Async reset mid-byte: counting restarts at the next edge.
    send_byte(8'h8A, 1'b0);
    sce = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs("rstn");
    send_byte(8'h5A, 1'b1);
    chk("rstn.addr", 32'(cap_addr), 32'd0);
    end_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
